// File: rtl/stream_unpack_if.sv
// Beat-to-word unpacker bus: wide source beat in, one word per cycle out.
// The master modport is the unpacker itself; slave is the environment around it.
interface stream_unpack_if #(
  parameter int WORDS = 32,
  parameter int WIDTH = 32
) ();
  logic                   src_valid;
  logic                   src_ready;
  logic [WORDS*WIDTH-1:0] src_data;
  logic                   src_last;
  logic                   dst_valid;
  logic                   dst_ready;
  logic [WIDTH-1:0]       dst_data;
  logic                   dst_last;
  logic                   busy;

  modport master (
    input  src_valid, src_data, src_last, dst_ready,
    output src_ready, dst_valid, dst_data, dst_last, busy
  );

  modport slave (
    output src_valid, src_data, src_last, dst_ready,
    input  src_ready, dst_valid, dst_data, dst_last, busy
  );
endinterface

// File: rtl/stream_unpack.sv
// Splits a WORDS*WIDTH source beat into WORDS sequential output words.
// Define STREAM_UNPACK_PREFETCH_EN to accept the next beat alongside the last word.
module stream_unpack #(
  parameter int WORDS = 32,
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  stream_unpack_if.master bus
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {EMPTY, DRAIN} state_t;

  state_t                      r_state;
  logic [WORDS-1:0][WIDTH-1:0] r_beat;
  logic                        r_last;
  logic [IDX_W-1:0]            r_idx;

  logic w_drain;
  logic w_last_word;
  logic w_dst_hs;
  logic w_prefetch;
  logic w_src_ready;
  logic w_src_hs;

  // Outputs are gated by rst so nothing is presented during the reset cycle itself.
  assign w_drain     = (r_state == DRAIN) && !rst;
  assign w_last_word = (r_idx == LAST_IDX);
  assign w_dst_hs    = w_drain && bus.dst_ready;

`ifdef STREAM_UNPACK_PREFETCH_EN
  assign w_prefetch = w_dst_hs && w_last_word;
`else
  assign w_prefetch = 1'b0;
`endif

  assign w_src_ready = !rst && ((r_state == EMPTY) || w_prefetch);
  assign w_src_hs    = bus.src_valid && w_src_ready;

  assign bus.src_ready = w_src_ready;
  assign bus.dst_valid = w_drain;
  assign bus.busy      = w_drain;
  assign bus.dst_data  = r_beat[r_idx];
  assign bus.dst_last  = w_drain && r_last && w_last_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_beat  <= '0;
      r_last  <= 1'b0;
      r_idx   <= '0;
    end else if (w_src_hs) begin
      // A new beat always wins, including the prefetch case on the final word.
      r_state <= DRAIN;
      r_beat  <= bus.src_data;
      r_last  <= bus.src_last;
      r_idx   <= '0;
    end else if (w_dst_hs) begin
      if (w_last_word) begin
        r_state <= EMPTY;
        r_idx   <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_stream_unpack.sv
// Scoreboard bench for stream_unpack: a 32-word and a 4-word instance.
module tb_stream_unpack;
`ifdef STREAM_UNPACK_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_unpack_if #(.WORDS(32), .WIDTH(32)) a ();
  stream_unpack_if #(.WORDS(4),  .WIDTH(32)) b ();

  stream_unpack #(.WORDS(32), .WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(a.master));
  stream_unpack #(.WORDS(4),  .WIDTH(32)) u_dut4  (.clk(clk), .rst(rst), .bus(b.master));

  typedef struct {
    logic [31:0] data;
    logic        last;
    int          idx;
    int          gap_src;
    int          gap_dst;
  } exp_t;

  exp_t q32[$];
  exp_t q4[$];
  exp_t e32, e4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc32 = 0;
  int last_src_cyc = 0;
  int last_dst_cyc = 0;
  bit prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic prev_last = 1'b0;
  bit pf_ok;

  bit bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int bp_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // dst_ready driver: held high, or the 1,0,0,1 stall pattern when bp_en is set.
  initial begin
    a.dst_ready = 1'b1;
    b.dst_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      a.dst_ready = bp_en ? bp_pat[bp_cnt % 4] : 1'b1;
      bp_cnt++;
    end
  end

  always @(negedge clk) begin : mon32
    if (rst) begin
      chk("rst_dst_valid", a.dst_valid, 0);
      chk("rst_dst_last", a.dst_last, 0);
      chk("rst_busy", a.busy, 0);
      chk("rst_src_ready", a.src_ready, 0);
      prev_stall = 1'b0;
    end else begin
      pf_ok = PF && a.dst_valid && a.dst_ready && (q32.size() > 0) && (q32[0].idx == W - 1);
      chk("src_ready", a.src_ready, !a.dst_valid || pf_ok);
      if (prev_stall) begin
        chk("hold_valid", a.dst_valid, 1);
        chk("hold_data", a.dst_data, prev_data);
        chk("hold_last", a.dst_last, prev_last);
      end
      if (a.dst_valid && a.dst_ready) begin
        if (q32.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", a.dst_data);
        end else begin
          e32 = q32.pop_front();
          chk("data", a.dst_data, e32.data);
          chk("last", a.dst_last, e32.last);
          if (e32.gap_src >= 0) chk("gap_src", cyc - last_src_cyc, e32.gap_src);
          if (e32.gap_dst >= 0) chk("gap_dst", cyc - last_dst_cyc, e32.gap_dst);
        end
        last_dst_cyc = cyc;
        acc32++;
      end
      if (a.src_valid && a.src_ready) last_src_cyc = cyc;
      prev_stall = a.dst_valid && !a.dst_ready;
      prev_data  = a.dst_data;
      prev_last  = a.dst_last;
    end
  end

  always @(negedge clk) begin : mon4
    if (!rst && b.dst_valid && b.dst_ready) begin
      if (q4.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word4 actual=%0h required=none", b.dst_data);
      end else begin
        e4 = q4.pop_front();
        chk("data4", b.dst_data, e4.data);
        chk("last4", b.dst_last, e4.last);
      end
    end
  end

  task automatic send32(input logic [31:0] base, input logic lst, input int g0_dst, input bit timed);
    int n;
    exp_t e;
    for (int k = 0; k < W; k++) begin
      e.data    = base + 32'(k);
      e.last    = lst && (k == W - 1);
      e.idx     = k;
      e.gap_src = (timed && k == 0) ? 1 : -1;
      e.gap_dst = (k == 0) ? g0_dst : (timed ? 1 : -1);
      q32.push_back(e);
      a.src_data[k*32 +: 32] = base + 32'(k);
    end
    a.src_last  = lst;
    a.src_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a.src_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("src_accept_timeout", n < 500, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send4(input logic [31:0] base);
    int n;
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.data = base + 32'(k);
      e.last = (k == 3);
      e.idx = k;
      e.gap_src = -1;
      e.gap_dst = -1;
      q4.push_back(e);
      b.src_data[k*32 +: 32] = base + 32'(k);
    end
    b.src_last  = 1'b1;
    b.src_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b.src_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("src_accept_timeout4", n < 500, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain32();
    int n = 0;
    while (q32.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_timeout", q32.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_acc32(input int target);
    int n = 0;
    while (acc32 < target && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("acc_timeout", acc32 >= target, 1);
  endtask

  initial begin
    int base;
    a.src_valid = 1'b0;
    a.src_data  = '0;
    a.src_last  = 1'b0;
    b.src_valid = 1'b0;
    b.src_data  = '0;
    b.src_last  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single beat, dst_ready held high.
    send32(32'h1000_0000, 1'b1, -1, 1'b1);
    a.src_valid = 1'b0;
    wait_drain32();

    // Back-pressure with the 1,0,0,1 pattern.
    bp_en = 1'b1;
    send32(32'h7000_0000, 1'b1, -1, 1'b0);
    a.src_valid = 1'b0;
    wait_drain32();
    bp_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back beats with src_valid held; last only on the second beat.
    send32(32'h2000_0000, 1'b0, -1, 1'b1);
    send32(32'h3000_0000, 1'b1, PF ? 1 : 2, 1'b1);
    a.src_valid = 1'b0;
    wait_drain32();

    // Reset pulse right after word 10, then a fresh beat.
    base = acc32;
    send32(32'h4000_0000, 1'b1, -1, 1'b1);
    a.src_valid = 1'b0;
    wait_acc32(base + 11);
    rst = 1'b1;
    q32.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", a.dst_valid, 0);
    @(posedge clk);
    #1;
    send32(32'h5000_0000, 1'b1, -1, 1'b1);
    a.src_valid = 1'b0;
    wait_drain32();

    // Source glitch while draining must not disturb the held beat.
    base = acc32;
    send32(32'h6000_0000, 1'b1, -1, 1'b1);
    a.src_valid = 1'b0;
    wait_acc32(base + 5);
    for (int k = 0; k < W; k++) a.src_data[k*32 +: 32] = 32'hDEAD_0000 + 32'(k);
    a.src_last  = 1'b0;
    a.src_valid = 1'b1;
    @(posedge clk);
    #1;
    a.src_valid = 1'b0;
    wait_drain32();

    // Four-word instance: two beats so idx wraps 3 -> 0.
    send4(32'h8000_0000);
    send4(32'h9000_0000);
    b.src_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("drain4", q4.size(), 0);
    chk("final_q32", q32.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/stream_unpack.md
STREAM_UNPACK -- requirements
Module: stream_unpack

Interface
REQ-001 SHALL have parameter WORDS, default 32, giving the number of words per source beat.
REQ-002 SHALL have parameter WIDTH, default 32, giving the bit width of each word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 SHALL have port src_valid, input, 1 bit: source beat valid, driven by the M_AXIS_TVALID of the upstream accelerator.
REQ-006 SHALL have port src_ready, output, 1 bit: source beat accept.
REQ-007 SHALL have port src_data, input, WORDS*WIDTH bits: the source beat, with word k at bits [WIDTH*k+WIDTH-1 : WIDTH*k].
REQ-008 SHALL have port src_last, input, 1 bit: marks the final beat of a packet.
REQ-009 SHALL have port dst_valid, output, 1 bit: output word valid.
REQ-010 SHALL have port dst_ready, input, 1 bit: output word accept.
REQ-011 SHALL have port dst_data, output, WIDTH bits: the current output word.
REQ-012 SHALL have port dst_last, output, 1 bit: marks the final word of a packet.
REQ-013 SHALL have port busy, output, 1 bit: high while a beat is held.

Function
REQ-014 SHALL implement two states, EMPTY and DRAIN, plus a beat register, a last-flag register and an index register idx of width clog2(WORDS).
REQ-015 SHALL drive src_ready high in EMPTY and low in DRAIN, except as extended by REQ-029.
REQ-016 SHALL treat a source handshake (src_valid & src_ready) as follows: capture src_data and src_last, set idx to 0, and enter DRAIN on the next edge.
REQ-017 SHALL drive dst_valid and busy high exactly when the state is DRAIN.
REQ-018 SHALL drive dst_data with word idx of the beat register.
REQ-019 SHALL make the first word valid one cycle after the source handshake; no combinational path from src to dst is permitted.
REQ-020 SHALL drive dst_last as (DRAIN & stored last & idx==WORDS-1).
REQ-021 SHALL increment idx by 1 on a dst handshake when idx < WORDS-1.
REQ-022 SHALL, on a dst handshake when idx == WORDS-1 and no new beat is accepted in the same cycle, return to EMPTY with idx at 0.
REQ-023 SHALL hold dst_data and dst_last stable while dst_valid is high and dst_ready is low.
REQ-024 SHALL ignore src_data and src_last when no source handshake occurs, so that a src_valid glitch while in DRAIN has no effect.
REQ-025 SHALL emit words strictly in order 0..WORDS-1; words shall never be dropped or duplicated.

Reset
REQ-026 SHALL, while rst is high, force the state to EMPTY, idx to 0, the stored last flag to 0 and the beat register to 0.
REQ-027 SHALL hold dst_valid, dst_last, busy and src_ready low while rst is high; src_ready rises in the first cycle after rst deasserts.
REQ-028 SHALL, when rst is asserted mid-beat, discard the remaining words; no dst_valid shall follow until a new source handshake.

Configuration
REQ-029 SHALL, when macro STREAM_UNPACK_PREFETCH_EN is defined, also assert src_ready in DRAIN when dst_valid & dst_ready & idx==WORDS-1. A beat accepted in that cycle loads the beat register, sets idx to 0 and stays in DRAIN, giving zero bubble between beats: steady state is WORDS words per WORDS cycles.
REQ-030 SHALL, without STREAM_UNPACK_PREFETCH_EN, accept beats only in EMPTY, which costs one idle dst cycle between consecutive beats: steady state is WORDS words per WORDS+1 cycles.

Verification
REQ-031 SHALL cover the single-beat case: rst 2 cycles, then one beat with word k = 32'h1000_0000+k and src_last=1 while dst_ready is held at 1 -> dst_data = 32'h1000_0000..32'h1000_001F on 32 consecutive cycles starting 1 cycle after the handshake, and dst_last high only on word 31.
REQ-032 SHALL cover back-pressure: dst_ready toggled 1,0,0,1 repeating -> every word is held stable while stalled, the order is unchanged, and src_ready stays 0 until word 31 is accepted.
REQ-033 SHALL cover back-to-back beats: two beats with src_valid held high and dst_ready=1 -> 64 words; the gap between word 31 and the next word 0 is 1 cycle without the macro and 0 cycles with it; dst_last is set only on the second beat's word 31 when src_last is set on that beat only.
REQ-034 SHALL cover reset mid-beat: rst pulsed for 1 cycle after word 10 -> dst_valid is 0 the next cycle, and a following beat restarts at word 0.
REQ-035 SHALL cover a source glitch: src_valid pulsed while in DRAIN without prefetch -> the beat register is unchanged and the output matches the first beat exactly.
REQ-036 SHALL cover the WORDS=4 parameterisation: for a 128-bit beat, idx wraps 3 -> 0 and dst_last is set on word 3.
